// File: rtl/colour_filter_pkg.sv
// Shared encodings and types for the streaming colour window filter.
package colour_filter_pkg;

    // Bounds are stored at a fixed maximum width so the struct serves any CW up to 16.
    localparam int MAX_CW = 16;

    localparam logic [1:0] MODE_BYPASS    = 2'd0;
    localparam logic [1:0] MODE_MASK      = 2'd1;
    localparam logic [1:0] MODE_BINARY    = 2'd2;
    localparam logic [1:0] MODE_HIGHLIGHT = 2'd3;

    localparam logic [2:0] FLD_RLO = 3'd0;
    localparam logic [2:0] FLD_RHI = 3'd1;
    localparam logic [2:0] FLD_GLO = 3'd2;
    localparam logic [2:0] FLD_GHI = 3'd3;
    localparam logic [2:0] FLD_BLO = 3'd4;
    localparam logic [2:0] FLD_BHI = 3'd5;

    typedef struct packed {
        logic [MAX_CW-1:0] r_lo;
        logic [MAX_CW-1:0] r_hi;
        logic [MAX_CW-1:0] g_lo;
        logic [MAX_CW-1:0] g_hi;
        logic [MAX_CW-1:0] b_lo;
        logic [MAX_CW-1:0] b_hi;
    } bounds_t;

    function automatic logic in_range(input logic [MAX_CW-1:0] ch,
                                      input logic [MAX_CW-1:0] lo,
                                      input logic [MAX_CW-1:0] hi);
        return (ch >= lo) && (ch <= hi);
    endfunction

endpackage

// File: rtl/colour_window_cmp.sv
// One colour window: registered inclusive lo/hi compare (S1) and a saturating per-frame hit counter (S2).
// Hit is valid one cycle after the pixel; frame_cnt snapshots the old count when the SOF tag leaves S1; no backpressure.
module colour_window_cmp
    import colour_filter_pkg::*;
#(
    parameter int CW    = 8,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  bounds_t          bounds,
    input  logic [CW-1:0]    red,
    input  logic [CW-1:0]    green,
    input  logic [CW-1:0]    blue,
    input  logic             s1_valid,
    input  logic             s1_sof,
    output logic             hit,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;
    logic             in_win;

    assign in_win = en
        && in_range(MAX_CW'(red),   bounds.r_lo, bounds.r_hi)
        && in_range(MAX_CW'(green), bounds.g_lo, bounds.g_hi)
        && in_range(MAX_CW'(blue),  bounds.b_lo, bounds.b_hi);

    always_ff @(posedge clk) begin
        if (rst) begin
            hit <= 1'b0;
        end else begin
            hit <= in_win;
        end
    end

    // The pixel carrying the SOF tag is the first pixel of the fresh frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            frame_cnt <= '0;
        end else if (s1_sof) begin
            frame_cnt <= cnt;
            cnt       <= CNT_W'(s1_valid && hit);
        end else if (s1_valid && hit && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/colour_window_filter.sv
// Per-pixel RGB window classifier with mode-selected output filter and per-frame match counts.
// Fixed 3-cycle latency, 1 pixel/cycle, no backpressure; config is shadowed and swapped in on iSOF.
module colour_window_filter
    import colour_filter_pkg::*;
#(
    parameter int CW      = 8,
    parameter int NUM_WIN = 4,
    parameter int CNT_W   = 20,
    parameter int AW      = $clog2(NUM_WIN) + 3
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [1:0]               iMODE,
    input  logic [NUM_WIN-1:0]       iWIN_EN,
    input  logic                     iCFG_WE,
    input  logic [AW-1:0]            iCFG_ADDR,
    input  logic [CW-1:0]            iCFG_DATA,
    input  logic                     iSOF,
    input  logic                     iValid,
    input  logic [CW-1:0]            iRed,
    input  logic [CW-1:0]            iGreen,
    input  logic [CW-1:0]            iBlue,
    output logic                     oValid,
    output logic [CW-1:0]            oRed,
    output logic [CW-1:0]            oGreen,
    output logic [CW-1:0]            oBlue,
    output logic [NUM_WIN-1:0]       oMatch,
    output logic [NUM_WIN*CNT_W-1:0] oCNT,
    output logic                     oFRAME_DONE
);

    logic                     s1_valid, s1_sof;
    logic [1:0]               s1_mode;
    logic [CW-1:0]            s1_r, s1_g, s1_b;
    logic [NUM_WIN-1:0]       s1_hit;
    logic [NUM_WIN*CNT_W-1:0] frame_cnt;

    logic                     s2_valid, s2_sof, s2_any;
    logic [1:0]               s2_mode;
    logic [CW-1:0]            s2_r, s2_g, s2_b, s2_gray;
    logic [NUM_WIN-1:0]       s2_match;

    logic [CW+1:0]            gray_sum;
    logic [CW-1:0]            mux_r, mux_g, mux_b;

    generate
        for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
            bounds_t shadow, active, eff;
            logic    en_q, en_eff;

            // A write coinciding with iSOF lands in shadow after the copy, so it waits for the next frame.
            always_ff @(posedge iCLK) begin
                if (iRST) begin
                    shadow <= '0;
                    active <= '0;
                    en_q   <= 1'b0;
                end else begin
                    if (iSOF) begin
                        active <= shadow;
                        en_q   <= iWIN_EN[w];
                    end
                    if (iCFG_WE && ((iCFG_ADDR >> 3) == AW'(w))) begin
                        case (iCFG_ADDR[2:0])
                            FLD_RLO: shadow.r_lo <= MAX_CW'(iCFG_DATA);
                            FLD_RHI: shadow.r_hi <= MAX_CW'(iCFG_DATA);
                            FLD_GLO: shadow.g_lo <= MAX_CW'(iCFG_DATA);
                            FLD_GHI: shadow.g_hi <= MAX_CW'(iCFG_DATA);
                            FLD_BLO: shadow.b_lo <= MAX_CW'(iCFG_DATA);
                            FLD_BHI: shadow.b_hi <= MAX_CW'(iCFG_DATA);
                            default: ;
                        endcase
                    end
                end
            end

            // The SOF pixel already belongs to the new frame and sees the incoming config.
            assign eff    = iSOF ? shadow : active;
            assign en_eff = iSOF ? iWIN_EN[w] : en_q;

            colour_window_cmp #(
                .CW    (CW),
                .CNT_W (CNT_W)
            ) u_cmp (
                .clk       (iCLK),
                .rst       (iRST),
                .en        (en_eff),
                .bounds    (eff),
                .red       (iRed),
                .green     (iGreen),
                .blue      (iBlue),
                .s1_valid  (s1_valid),
                .s1_sof    (s1_sof),
                .hit       (s1_hit[w]),
                .frame_cnt (frame_cnt[w*CNT_W +: CNT_W])
            );
        end
    endgenerate

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_mode  <= '0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= iValid;
            s1_sof   <= iSOF;
            s1_mode  <= iMODE;
            s1_r     <= iRed;
            s1_g     <= iGreen;
            s1_b     <= iBlue;
        end
    end

    assign gray_sum = {2'b00, s1_r} + {1'b0, s1_g, 1'b0} + {2'b00, s1_b};

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_mode  <= '0;
            s2_r     <= '0;
            s2_g     <= '0;
            s2_b     <= '0;
            s2_any   <= 1'b0;
            s2_gray  <= '0;
            s2_match <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_mode  <= s1_mode;
            s2_r     <= s1_r;
            s2_g     <= s1_g;
            s2_b     <= s1_b;
            s2_any   <= |s1_hit;
            s2_gray  <= gray_sum[CW+1:2];
            s2_match <= s1_hit;
        end
    end

    always_comb begin
        mux_r = s2_r;
        mux_g = s2_g;
        mux_b = s2_b;
        case (s2_mode)
            MODE_BYPASS: ;
            MODE_MASK: begin
                if (!s2_any) begin
                    mux_r = '0;
                    mux_g = '0;
                    mux_b = '0;
                end
            end
            MODE_BINARY: begin
                mux_r = {CW{s2_any}};
                mux_g = {CW{s2_any}};
                mux_b = {CW{s2_any}};
            end
            MODE_HIGHLIGHT: begin
                if (!s2_any) begin
                    mux_r = s2_gray;
                    mux_g = s2_gray;
                    mux_b = s2_gray;
                end
            end
            default: ;
        endcase
    end

    // Pixel and match outputs hold their last value while oValid is low.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oValid      <= 1'b0;
            oRed        <= '0;
            oGreen      <= '0;
            oBlue       <= '0;
            oMatch      <= '0;
            oCNT        <= '0;
            oFRAME_DONE <= 1'b0;
        end else begin
            oValid      <= s2_valid;
            oFRAME_DONE <= s2_sof;
            if (s2_valid) begin
                oRed   <= mux_r;
                oGreen <= mux_g;
                oBlue  <= mux_b;
                oMatch <= s2_match;
            end
            if (s2_sof) begin
                oCNT <= frame_cnt;
            end
        end
    end

endmodule

// File: tb/tb_colour_window_filter.sv
// Randomised and directed bench for colour_window_filter against a per-frame behavioural model.
module tb_colour_window_filter;
    import colour_filter_pkg::*;

    localparam int CW      = 8;
    localparam int NUM_WIN = 4;
    localparam int CNT_W   = 4;
    localparam int AW      = 5;
    localparam int NCYC    = 4096;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [1:0]               mode = '0;
    logic [NUM_WIN-1:0]       win_en = '0;
    logic                     cfg_we = 1'b0;
    logic [AW-1:0]            cfg_addr = '0;
    logic [CW-1:0]            cfg_data = '0;
    logic                     sof = 1'b0;
    logic                     valid = 1'b0;
    logic [CW-1:0]            red = '0, green = '0, blue = '0;
    logic                     out_valid;
    logic [CW-1:0]            out_r, out_g, out_b;
    logic [NUM_WIN-1:0]       out_match;
    logic [NUM_WIN*CNT_W-1:0] out_cnt;
    logic                     out_fd;

    colour_window_filter #(
        .CW(CW), .NUM_WIN(NUM_WIN), .CNT_W(CNT_W), .AW(AW)
    ) dut (
        .iCLK(clk), .iRST(rst), .iMODE(mode), .iWIN_EN(win_en),
        .iCFG_WE(cfg_we), .iCFG_ADDR(cfg_addr), .iCFG_DATA(cfg_data),
        .iSOF(sof), .iValid(valid), .iRed(red), .iGreen(green), .iBlue(blue),
        .oValid(out_valid), .oRed(out_r), .oGreen(out_g), .oBlue(out_b),
        .oMatch(out_match), .oCNT(out_cnt), .oFRAME_DONE(out_fd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ec = 0;

    // Reference state: configuration as seen by software, and per-window counts for the current frame.
    int                 m_shadow [NUM_WIN][6];
    int                 m_active [NUM_WIN][6];
    logic [NUM_WIN-1:0] m_en = '0;
    int                 m_cnt [NUM_WIN];

    bit                       s_v   [NCYC];
    logic [CW-1:0]            s_r   [NCYC];
    logic [CW-1:0]            s_g   [NCYC];
    logic [CW-1:0]            s_b   [NCYC];
    logic [NUM_WIN-1:0]       s_m   [NCYC];
    bit                       s_fd  [NCYC];
    logic [NUM_WIN*CNT_W-1:0] s_cnt [NCYC];

    logic                     e_v, e_fd;
    logic [CW-1:0]            e_r, e_g, e_b;
    logic [NUM_WIN-1:0]       e_m;
    logic [NUM_WIN*CNT_W-1:0] e_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, ec, got, exp);
        end
    endtask

    task automatic step();
        int                 e, pr, pg, pb, gray;
        logic [NUM_WIN-1:0] hits;
        e = ec;
        if (rst) begin
            for (int k = e; k < e + 3; k++) begin
                s_v[k]  = 1'b0;
                s_fd[k] = 1'b0;
            end
            for (int w = 0; w < NUM_WIN; w++) begin
                for (int f = 0; f < 6; f++) begin
                    m_shadow[w][f] = 0;
                    m_active[w][f] = 0;
                end
                m_cnt[w] = 0;
            end
            m_en = '0;
        end else begin
            if (sof) begin
                for (int w = 0; w < NUM_WIN; w++)
                    for (int f = 0; f < 6; f++)
                        m_active[w][f] = m_shadow[w][f];
                m_en = win_en;
                s_fd[e+2] = 1'b1;
                for (int w = 0; w < NUM_WIN; w++) begin
                    s_cnt[e+2][w*CNT_W +: CNT_W] = CNT_W'(m_cnt[w]);
                    m_cnt[w] = 0;
                end
            end
            pr = int'(red);
            pg = int'(green);
            pb = int'(blue);
            hits = '0;
            for (int w = 0; w < NUM_WIN; w++)
                if (m_en[w] && pr >= m_active[w][0] && pr <= m_active[w][1]
                            && pg >= m_active[w][2] && pg <= m_active[w][3]
                            && pb >= m_active[w][4] && pb <= m_active[w][5])
                    hits[w] = 1'b1;
            if (valid) begin
                gray = (pr + 2 * pg + pb) / 4;
                s_v[e+2] = 1'b1;
                s_m[e+2] = hits;
                s_r[e+2] = red;
                s_g[e+2] = green;
                s_b[e+2] = blue;
                case (mode)
                    MODE_MASK: if (hits == 0) begin
                        s_r[e+2] = 0; s_g[e+2] = 0; s_b[e+2] = 0;
                    end
                    MODE_BINARY: begin
                        s_r[e+2] = (hits != 0) ? 8'hFF : 8'h00;
                        s_g[e+2] = s_r[e+2];
                        s_b[e+2] = s_r[e+2];
                    end
                    MODE_HIGHLIGHT: if (hits == 0) begin
                        s_r[e+2] = CW'(gray); s_g[e+2] = CW'(gray); s_b[e+2] = CW'(gray);
                    end
                    default: ;
                endcase
                for (int w = 0; w < NUM_WIN; w++)
                    if (hits[w] && m_cnt[w] < CNT_MAX) m_cnt[w]++;
            end
            if (cfg_we && cfg_addr[2:0] < 3'd6)
                m_shadow[cfg_addr[4:3]][cfg_addr[2:0]] = int'(cfg_data);
        end

        @(posedge clk);
        if (rst) begin
            e_v = 0; e_r = 0; e_g = 0; e_b = 0; e_m = 0; e_fd = 0; e_cnt = 0;
        end else begin
            e_v = s_v[e];
            if (s_v[e]) begin
                e_r = s_r[e]; e_g = s_g[e]; e_b = s_b[e]; e_m = s_m[e];
            end
            e_fd = s_fd[e];
            if (s_fd[e]) e_cnt = s_cnt[e];
        end
        #1;
        check("oValid",      64'(out_valid), 64'(e_v));
        check("oRed",        64'(out_r),     64'(e_r));
        check("oGreen",      64'(out_g),     64'(e_g));
        check("oBlue",       64'(out_b),     64'(e_b));
        check("oMatch",      64'(out_match), 64'(e_m));
        check("oFRAME_DONE", 64'(out_fd),    64'(e_fd));
        check("oCNT",        64'(out_cnt),   64'(e_cnt));
        ec++;
    endtask

    task automatic pix(input int r, input int g, input int b, input logic [1:0] md);
        valid = 1'b1; red = CW'(r); green = CW'(g); blue = CW'(b); mode = md;
        step();
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int win, input logic [2:0] fld, input int data);
        cfg_we = 1'b1; cfg_addr = {2'(win), fld}; cfg_data = CW'(data);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic sof_pulse();
        sof = 1'b1;
        step();
        sof = 1'b0;
    endtask

    function automatic logic [CW-1:0] pick();
        case ($urandom_range(0, 9))
            0: return 8'd0;
            1: return 8'd49;
            2: return 8'd50;
            3: return 8'd51;
            4: return 8'd127;
            5: return 8'd200;
            6: return 8'd254;
            7: return 8'd255;
            default: return CW'($urandom);
        endcase
    endfunction

    initial begin
        idle(2);
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            pix(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), MODE_MASK);
        idle(3);

        wr(0, FLD_RLO, 200); wr(0, FLD_RHI, 255); wr(0, FLD_GLO, 0);
        wr(0, FLD_GHI, 50);  wr(0, FLD_BLO, 0);   wr(0, FLD_BHI, 50);
        win_en = 4'b0001;
        sof_pulse();
        pix(220, 30, 10, MODE_BINARY);
        pix(100, 30, 10, MODE_BINARY);
        pix(40, 80, 120, MODE_HIGHLIGHT);
        idle(3);

        wr(1, FLD_RLO, 0); wr(1, FLD_RHI, 99);  wr(1, FLD_GLO, 0);
        wr(1, FLD_GHI, 255); wr(1, FLD_BLO, 0); wr(1, FLD_BHI, 255);
        win_en = 4'b0011;
        sof_pulse();
        for (int i = 0; i < 10; i++)
            pix((i < 7) ? 10 + i : 150, 20, 30, MODE_MASK);
        idle(2);
        sof_pulse();
        idle(4);

        pix(120, 20, 30, MODE_BINARY);
        wr(1, FLD_RHI, 150);
        pix(120, 20, 30, MODE_BINARY);
        pix(99, 20, 30, MODE_BINARY);
        // SOF with a pixel and a same-cycle write that must wait for the following frame.
        sof = 1'b1; cfg_we = 1'b1; cfg_addr = {2'd1, FLD_RLO}; cfg_data = 8'd130;
        pix(120, 20, 30, MODE_BINARY);
        sof = 1'b0; cfg_we = 1'b0;
        pix(110, 20, 30, MODE_BINARY);
        idle(3);

        sof_pulse();
        for (int i = 0; i < 20; i++) pix(140, 0, 0, MODE_BYPASS);
        sof_pulse();
        idle(4);

        for (int i = 0; i < 4; i++) pix(140, 1, 1, MODE_MASK);
        rst = 1'b1;
        pix(140, 1, 1, MODE_MASK);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) pix(0, 0, 0, MODE_BYPASS);

        win_en = 4'hF;
        for (int i = 0; i < 2000; i++) begin
            valid    = ($urandom_range(0, 3) != 0);
            mode     = 2'($urandom_range(0, 3));
            sof      = ($urandom_range(0, 40) == 0);
            if (sof && $urandom_range(0, 1) == 1) win_en = NUM_WIN'($urandom);
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_addr = AW'($urandom);
            cfg_data = pick();
            red      = pick();
            green    = pick();
            blue     = pick();
            rst      = ($urandom_range(0, 700) == 0);
            step();
        end
        rst = 1'b0; sof = 1'b0; cfg_we = 1'b0; valid = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
